// File: rtl/myo_spi_frame_monitor_if.sv
// Tap bundle for one myocontrol SPI conduit. The master modport is the side
// that drives the pins; the monitor only ever uses the slave modport.
interface myo_spi_frame_monitor_if #(
  parameter int NUM_SS = 9
);
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (output sck, output mosi, output miso, output ss_n);
  modport slave  (input  sck, input  mosi, input  miso, input  ss_n);
endinterface

// File: rtl/myo_spi_frame_monitor.sv
// Passive oversampling decoder for a myocontrol SPI conduit (mode 0, MSB first).
// It reports a per-frame summary, keeps sticky protocol-error flags and drives status LEDs.
module myo_spi_frame_monitor #(
  parameter int NUM_SS      = 9,   // at most 16
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2    // at least 2
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  myo_spi_frame_monitor_if.slave   spi,
  input  logic                     power_sense_n,
  input  logic                     err_clear,
  output logic                     frame_valid,
  output logic [3:0]               frame_slave,
  output logic [7:0]               frame_words,
  output logic [WORD_BITS-1:0]     first_mosi_word,
  output logic [WORD_BITS-1:0]     first_miso_word,
  output logic                     err_multi_ss,
  output logic                     err_partial_word,
  output logic [7:0]               led
);

  localparam int BIT_W    = $clog2(WORD_BITS + 1);
  localparam int PIN_SCK  = 0;
  localparam int PIN_MOSI = 1;
  localparam int PIN_MISO = 2;
  localparam int PIN_PWR  = 3;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, WAIT_IDLE} state_e;

  // Selects and power are synchronized inverted (active-high) so that the
  // all-zero reset value means "nothing selected, no power".
  logic [SYNC_STAGES-1:0][NUM_SS-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0][3:0]        pin_sync_q, pin_sync_d;
  logic [SYNC_STAGES:0]               fill_q, fill_d;
  logic                               sck_prev_q, sck_prev_d;

  // Registered decode of the synchronized pins
  logic       dec_none_q, dec_none_d;
  logic       dec_one_q, dec_one_d;
  logic       dec_multi_q, dec_multi_d;
  logic [3:0] dec_idx_q, dec_idx_d;
  logic       dec_pwr_q, dec_pwr_d;
  logic       dec_rise_q, dec_rise_d;
  logic       dec_mosi_q, dec_mosi_d;
  logic       dec_miso_q, dec_miso_d;

  // Frame tracking
  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic [3:0]           slave_q, slave_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0] mosi_sr_q, mosi_sr_d;
  logic [WORD_BITS-1:0] miso_sr_q, miso_sr_d;
  logic [WORD_BITS-1:0] mosi_first_q, mosi_first_d;
  logic [WORD_BITS-1:0] miso_first_q, miso_first_d;

  // Reported outputs
  logic                 frame_valid_q, frame_valid_d;
  logic [3:0]           frame_slave_q, frame_slave_d;
  logic [7:0]           frame_words_q, frame_words_d;
  logic [WORD_BITS-1:0] first_mosi_q, first_mosi_d;
  logic [WORD_BITS-1:0] first_miso_q, first_miso_d;
  logic                 err_multi_q, err_multi_d;
  logic                 err_partial_q, err_partial_d;
  logic                 led_toggle_q, led_toggle_d;
  logic                 set_multi, set_partial;

  logic [NUM_SS-1:0]    ss_act;
  logic [4:0]           n_act;

  always_comb begin : sync_comb
    ss_sync_d[0]  = ~spi.ss_n;
    pin_sync_d[0] = {~power_sense_n, spi.miso, spi.mosi, spi.sck};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ss_sync_d[i]  = ss_sync_q[i-1];
      pin_sync_d[i] = pin_sync_q[i-1];
    end
    // fill_q[SYNC_STAGES] marks the decode stage as holding sampled pin data
    fill_d     = {fill_q[SYNC_STAGES-1:0], 1'b1};
    sck_prev_d = pin_sync_q[SYNC_STAGES-1][PIN_SCK];
  end

  always_comb begin : decode_comb
    ss_act    = ss_sync_q[SYNC_STAGES-1];
    n_act     = '0;
    dec_idx_d = '0;
    for (int i = 0; i < NUM_SS; i++) begin
      if (ss_act[i]) begin
        n_act     = n_act + 5'd1;
        dec_idx_d = 4'(i);
      end
    end
    dec_none_d  = (n_act == 5'd0);
    dec_one_d   = (n_act == 5'd1);
    dec_multi_d = (n_act > 5'd1);
    dec_pwr_d   = pin_sync_q[SYNC_STAGES-1][PIN_PWR];
    dec_rise_d  = pin_sync_q[SYNC_STAGES-1][PIN_SCK] & ~sck_prev_q;
    dec_mosi_d  = pin_sync_q[SYNC_STAGES-1][PIN_MOSI];
    dec_miso_d  = pin_sync_q[SYNC_STAGES-1][PIN_MISO];
  end

  always_comb begin : fsm_comb
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d       = state_q;
    slave_d       = slave_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    mosi_sr_d     = mosi_sr_q;
    miso_sr_d     = miso_sr_q;
    mosi_first_d  = mosi_first_q;
    miso_first_d  = miso_first_q;
    frame_valid_d = 1'b0;
    frame_slave_d = frame_slave_q;
    frame_words_d = frame_words_q;
    first_mosi_d  = first_mosi_q;
    first_miso_d  = first_miso_q;
    led_toggle_d  = led_toggle_q;
    set_multi     = 1'b0;
    set_partial   = 1'b0;

    // A frame may only start after a clean all-released select has been seen,
    // so a transfer already running when reset releases is ignored.
    armed_d = armed_q | (fill_q[SYNC_STAGES] & dec_none_q);

    unique case (state_q)
      IDLE: begin
        if (armed_q) begin
          if (dec_one_q && dec_pwr_q) begin
            state_d    = ACTIVE;
            slave_d    = dec_idx_q;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
          end else if (dec_multi_q) begin
            set_multi = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end
      end

      ACTIVE: begin
        // The edge is consumed before the exit checks, so an edge coinciding
        // with select release is still counted in this frame.
        if (dec_rise_q) begin
          mosi_sr_d = {mosi_sr_q[WORD_BITS-2:0], dec_mosi_q};
          miso_sr_d = {miso_sr_q[WORD_BITS-2:0], dec_miso_q};
          if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
            bit_cnt_d = '0;
            if (word_cnt_q != 8'hFF) word_cnt_d = word_cnt_q + 8'd1;
            if (word_cnt_q == 8'd0) begin
              mosi_first_d = mosi_sr_d;
              miso_first_d = miso_sr_d;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end

        if (dec_none_q) begin
          state_d = DONE;
        end else if (!dec_pwr_q) begin
          state_d = WAIT_IDLE;
        end else if (!(dec_one_q && (dec_idx_q == slave_q))) begin
          set_multi = 1'b1;
          state_d   = WAIT_IDLE;
        end
      end

      DONE: begin
        if (bit_cnt_q != '0) set_partial = 1'b1;
        if (word_cnt_q != 8'd0) begin
          frame_valid_d = 1'b1;
          frame_slave_d = slave_q;
          frame_words_d = word_cnt_q;
          first_mosi_d  = mosi_first_q;
          first_miso_d  = miso_first_q;
          led_toggle_d  = ~led_toggle_q;
        end
        state_d = IDLE;
      end

      WAIT_IDLE: begin
        if (dec_none_q) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Setting has priority over a coincident clear
    err_multi_d   = set_multi   | (err_multi_q   & ~err_clear);
    err_partial_d = set_partial | (err_partial_q & ~err_clear);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ss_sync_q     <= '0;
      pin_sync_q    <= '0;
      fill_q        <= '0;
      sck_prev_q    <= 1'b0;
      dec_none_q    <= 1'b0;
      dec_one_q     <= 1'b0;
      dec_multi_q   <= 1'b0;
      dec_idx_q     <= '0;
      dec_pwr_q     <= 1'b0;
      dec_rise_q    <= 1'b0;
      dec_mosi_q    <= 1'b0;
      dec_miso_q    <= 1'b0;
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      slave_q       <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      mosi_sr_q     <= '0;
      miso_sr_q     <= '0;
      mosi_first_q  <= '0;
      miso_first_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_slave_q <= '0;
      frame_words_q <= '0;
      first_mosi_q  <= '0;
      first_miso_q  <= '0;
      err_multi_q   <= 1'b0;
      err_partial_q <= 1'b0;
      led_toggle_q  <= 1'b0;
    end else begin
      ss_sync_q     <= ss_sync_d;
      pin_sync_q    <= pin_sync_d;
      fill_q        <= fill_d;
      sck_prev_q    <= sck_prev_d;
      dec_none_q    <= dec_none_d;
      dec_one_q     <= dec_one_d;
      dec_multi_q   <= dec_multi_d;
      dec_idx_q     <= dec_idx_d;
      dec_pwr_q     <= dec_pwr_d;
      dec_rise_q    <= dec_rise_d;
      dec_mosi_q    <= dec_mosi_d;
      dec_miso_q    <= dec_miso_d;
      state_q       <= state_d;
      armed_q       <= armed_d;
      slave_q       <= slave_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      mosi_sr_q     <= mosi_sr_d;
      miso_sr_q     <= miso_sr_d;
      mosi_first_q  <= mosi_first_d;
      miso_first_q  <= miso_first_d;
      frame_valid_q <= frame_valid_d;
      frame_slave_q <= frame_slave_d;
      frame_words_q <= frame_words_d;
      first_mosi_q  <= first_mosi_d;
      first_miso_q  <= first_miso_d;
      err_multi_q   <= err_multi_d;
      err_partial_q <= err_partial_d;
      led_toggle_q  <= led_toggle_d;
    end
  end

  assign frame_valid      = frame_valid_q;
  assign frame_slave      = frame_slave_q;
  assign frame_words      = frame_words_q;
  assign first_mosi_word  = first_mosi_q;
  assign first_miso_word  = first_miso_q;
  assign err_multi_ss     = err_multi_q;
  assign err_partial_word = err_partial_q;
  assign led = {led_toggle_q, pin_sync_q[SYNC_STAGES-1][PIN_PWR],
                err_partial_q, err_multi_q, frame_slave_q};

endmodule

// File: tb/tb_myo_spi_frame_monitor.sv
// Directed bench for myo_spi_frame_monitor: drives SPI frames on the tap
// interface and checks frame summaries, sticky errors, LEDs and latency.
module tb_myo_spi_frame_monitor;

  localparam int NUM_SS      = 9;
  localparam int WORD_BITS   = 16;
  localparam int SYNC_STAGES = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 power_sense_n;
  logic                 err_clear;
  logic                 frame_valid;
  logic [3:0]           frame_slave;
  logic [7:0]           frame_words;
  logic [WORD_BITS-1:0] first_mosi_word;
  logic [WORD_BITS-1:0] first_miso_word;
  logic                 err_multi_ss;
  logic                 err_partial_word;
  logic [7:0]           led;

  myo_spi_frame_monitor_if #(.NUM_SS(NUM_SS)) spi_if ();

  myo_spi_frame_monitor #(
    .NUM_SS(NUM_SS), .WORD_BITS(WORD_BITS), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .spi              (spi_if),
    .power_sense_n    (power_sense_n),
    .err_clear        (err_clear),
    .frame_valid      (frame_valid),
    .frame_slave      (frame_slave),
    .frame_words      (frame_words),
    .first_mosi_word  (first_mosi_word),
    .first_miso_word  (first_miso_word),
    .err_multi_ss     (err_multi_ss),
    .err_partial_word (err_partial_word),
    .led              (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts frame_valid pulses and captures the summary seen with them
  int         fv_cnt = 0;
  int         fv_cyc = 0;
  logic [3:0] fv_slave = '0;
  logic [7:0] fv_words = '0;
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt   = fv_cnt + 1;
      fv_cyc   = cyc;
      fv_slave = frame_slave;
      fv_words = frame_words;
    end
  end

  int n_pass  = 0;
  int n_total = 0;
  int rel_cyc = 0;
  int fv_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode 0: data changes while sck is low, the monitor samples on the rise
  task automatic send_bits(input int nbits, input logic [63:0] mo, input logic [63:0] mi);
    for (int k = 0; k < nbits; k++) begin
      spi_if.sck  = 1'b0;
      spi_if.mosi = mo[nbits-1-k];
      spi_if.miso = mi[nbits-1-k];
      clks(4);
      spi_if.sck = 1'b1;
      clks(4);
    end
    spi_if.sck = 1'b0;
    clks(4);
  endtask

  task automatic release_ss();
    spi_if.ss_n = '1;
    rel_cyc = cyc;
    clks(12);
  endtask

  task automatic frame(input logic [8:0] ss, input int nbits,
                       input logic [63:0] mo, input logic [63:0] mi);
    spi_if.ss_n = ss;
    clks(4);
    send_bits(nbits, mo, mi);
    release_ss();
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    clks(1);
    err_clear = 1'b0;
    clks(2);
  endtask

  initial begin
    spi_if.sck    = 1'b0;
    spi_if.mosi   = 1'b0;
    spi_if.miso   = 1'b0;
    spi_if.ss_n   = '1;
    power_sense_n = 1'b0;
    err_clear     = 1'b0;
    rst_n         = 1'b0;
    clks(4);

    check("rst_frame_valid", 32'(frame_valid), 0);
    check("rst_slave_words", {frame_slave, frame_words}, 0);
    check("rst_first_mosi", 32'(first_mosi_word), 0);
    check("rst_first_miso", 32'(first_miso_word), 0);
    check("rst_errors", {err_multi_ss, err_partial_word}, 0);
    check("rst_led", 32'(led), 0);

    rst_n = 1'b1;
    clks(10);
    check("idle_led_power", 32'(led), 32'h40);

    // Single word to slave 3
    fv_base = fv_cnt;
    frame(9'h1F7, 16, 64'hA5C3, 64'h1234);
    check("t1_pulses", fv_cnt - fv_base, 1);
    // Release is first sampled one edge after rel_cyc, then SYNC_STAGES+2 more edges
    check("t1_latency", fv_cyc - rel_cyc, 1 + SYNC_STAGES + 2);
    check("t1_slave_at_pulse", 32'(fv_slave), 3);
    check("t1_words_at_pulse", 32'(fv_words), 1);
    check("t1_slave", 32'(frame_slave), 3);
    check("t1_words", 32'(frame_words), 1);
    check("t1_mosi", 32'(first_mosi_word), 32'hA5C3);
    check("t1_miso", 32'(first_miso_word), 32'h1234);
    check("t1_errors", {err_multi_ss, err_partial_word}, 0);
    check("t1_led", 32'(led), 32'hC3);

    // Three words to slave 8
    fv_base = fv_cnt;
    frame(9'h0FF, 48, 64'h8001_FFFF_0000, 64'h0F0F_0000_FFFF);
    check("t2_pulses", fv_cnt - fv_base, 1);
    check("t2_slave", 32'(frame_slave), 8);
    check("t2_words", 32'(frame_words), 3);
    check("t2_mosi", 32'(first_mosi_word), 32'h8001);
    check("t2_miso", 32'(first_miso_word), 32'h0F0F);
    check("t2_led", 32'(led), 32'h48);

    // One word plus a 4-bit tail to slave 0
    fv_base = fv_cnt;
    frame(9'h1FE, 20, 64'h3C3CF, 64'hBEEF0);
    check("t3_pulses", fv_cnt - fv_base, 1);
    check("t3_slave", 32'(frame_slave), 0);
    check("t3_words", 32'(frame_words), 1);
    check("t3_mosi", 32'(first_mosi_word), 32'h3C3C);
    check("t3_miso", 32'(first_miso_word), 32'hBEEF);
    check("t3_errors", {err_multi_ss, err_partial_word}, 2'b01);
    check("t3_led", 32'(led), 32'hE0);
    pulse_clear();
    check("t3_clear_led", 32'(led), 32'hC0);

    // Only 7 bits: partial error, no frame, summary unchanged
    fv_base = fv_cnt;
    frame(9'h1DF, 7, 64'h55, 64'h2A);
    check("t4_pulses", fv_cnt - fv_base, 0);
    check("t4_errors", {err_multi_ss, err_partial_word}, 2'b01);
    check("t4_summary_held", {frame_slave, frame_words}, {4'd0, 8'd1});
    pulse_clear();

    // Two selects low at once
    fv_base = fv_cnt;
    spi_if.ss_n = 9'h1FC;
    clks(8);
    release_ss();
    check("t5_pulses", fv_cnt - fv_base, 0);
    check("t5_errors", {err_multi_ss, err_partial_word}, 2'b10);
    check("t5_led", 32'(led), 32'hD0);
    pulse_clear();
    check("t5_clear", {err_multi_ss, err_partial_word}, 0);

    // Select moves from slave 2 to slave 5 mid-frame
    fv_base = fv_cnt;
    spi_if.ss_n = 9'h1FB;
    clks(4);
    send_bits(8, 64'hA5, 64'h5A);
    spi_if.ss_n = 9'h1DF;
    clks(4);
    send_bits(8, 64'h3C, 64'hC3);
    release_ss();
    check("t6_pulses", fv_cnt - fv_base, 0);
    check("t6_errors", {err_multi_ss, err_partial_word}, 2'b10);
    pulse_clear();
    check("t6_clear", {err_multi_ss, err_partial_word}, 0);

    // Power lost after 8 bits: frame dropped silently
    fv_base = fv_cnt;
    spi_if.ss_n = 9'h1FD;
    clks(4);
    send_bits(8, 64'hFF, 64'h00);
    power_sense_n = 1'b1;
    clks(4);
    send_bits(8, 64'hFF, 64'h00);
    release_ss();
    check("t7_pulses", fv_cnt - fv_base, 0);
    check("t7_errors", {err_multi_ss, err_partial_word}, 0);
    check("t7_led", 32'(led), 32'h80);
    power_sense_n = 1'b0;
    clks(6);

    // Reset mid-frame; the frame still running at reset release must be ignored
    fv_base = fv_cnt;
    spi_if.ss_n = 9'h1EF;
    clks(4);
    send_bits(8, 64'h81, 64'h18);
    rst_n = 1'b0;
    clks(3);
    check("t8_rst_frame_valid", 32'(frame_valid), 0);
    check("t8_rst_summary", {frame_slave, frame_words}, 0);
    check("t8_rst_words", {first_mosi_word, first_miso_word}, 0);
    check("t8_rst_errors", {err_multi_ss, err_partial_word}, 0);
    check("t8_rst_led", 32'(led), 0);
    rst_n = 1'b1;
    send_bits(16, 64'hFFFF, 64'hFFFF);
    release_ss();
    check("t8_no_stale_frame", fv_cnt - fv_base, 0);
    check("t8_no_stale_errors", {err_multi_ss, err_partial_word}, 0);

    fv_base = fv_cnt;
    frame(9'h1BF, 16, 64'h0F0F, 64'hF0F0);
    check("t8_pulses", fv_cnt - fv_base, 1);
    check("t8_latency", fv_cyc - rel_cyc, 1 + SYNC_STAGES + 2);
    check("t8_slave", 32'(frame_slave), 6);
    check("t8_words", 32'(frame_words), 1);
    check("t8_mosi", 32'(first_mosi_word), 32'h0F0F);
    check("t8_miso", 32'(first_miso_word), 32'hF0F0);
    check("t8_led", 32'(led), 32'hC6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
